// File: rtl/i2s_data_sync.sv
// i2s_data_sync: carries one multi-bit word at a time from the I2S bit-clock
// domain (clk2) to the system domain (clk1) with a four-phase req/ack handshake.
//
// Ports:
//   clk1, rst1_n  : destination (system) clock, async active-low reset
//   clk2, rst2_n  : source (I2S) clock, async active-low reset
//   src_data      : word offered by the I2S receiver shifter (clk2)
//   src_valid     : one-cycle strobe qualifying src_data (clk2)
//   src_busy      : a transfer is in flight; a new word would be dropped (clk2)
//   src_overrun   : one-cycle pulse, a word was dropped because src_busy=1 (clk2)
//   dst_data      : delivered word (clk1)
//   dst_valid     : dst_data holds an unconsumed word (clk1)
//   dst_ready     : consumer takes dst_data when dst_valid & dst_ready (clk1)
`timescale 1ns/1ps

module i2s_data_sync #(
    parameter int DW = 32
) (
    input  logic          clk1,
    input  logic          rst1_n,
    input  logic          clk2,
    input  logic          rst2_n,
    input  logic [DW-1:0] src_data,
    input  logic          src_valid,
    output logic          src_busy,
    output logic          src_overrun,
    output logic [DW-1:0] dst_data,
    output logic          dst_valid,
    input  logic          dst_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // clk2 (source) side
    // ------------------------------------------------------------------
    logic          req;
    logic [DW-1:0] hold;
    logic          ack_m;
    logic          ack_s;

    // clk1 side state, declared here because ack feeds the clk2 synchroniser
    logic          ack;

    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ack;
            ack_s <= ack_m;
        end
    end

    // Busy covers the whole round trip: req high, then until ack is seen low.
    assign src_busy = req | ack_s;

    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            req         <= 1'b0;
            hold        <= '0;
            src_overrun <= 1'b0;
        end else begin
            src_overrun <= src_valid & src_busy;
            if (src_valid && !src_busy) begin
                hold <= src_data;
                req  <= 1'b1;
            end else if (ack_s) begin
                req  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // clk1 (destination) side
    // ------------------------------------------------------------------
    logic   req_m;
    logic   req_s;
    state_t state;
    state_t state_d;
    logic   ack_d;
    logic   capture;
    logic   buf_free;

    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            req_m <= 1'b0;
            req_s <= 1'b0;
        end else begin
            req_m <= req;
            req_s <= req_m;
        end
    end

    // The output slot may be refilled on the same edge it is drained.
    assign buf_free = ~dst_valid | dst_ready;

    always_comb begin
        state_d = state;
        ack_d   = ack;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                // hold is stable whenever req_s is high, so it is safe to
                // sample the bus here. Without room we simply do not ack,
                // which keeps the source busy.
                if (req_s && buf_free) begin
                    capture = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            state <= IDLE;
            ack   <= 1'b0;
        end else begin
            state <= state_d;
            ack   <= ack_d;
        end
    end

    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            dst_data  <= '0;
            dst_valid <= 1'b0;
        end else begin
            if (capture) begin
                dst_data  <= hold;
                dst_valid <= 1'b1;
            end else if (dst_ready) begin
                dst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_data_sync.sv
// tb_i2s_data_sync: directed bench for i2s_data_sync; single word, overrun,
// backpressure, reset cases and a random stream over three clock ratios.
`timescale 1ns/1ps

module tb_i2s_data_sync;

    localparam int DW = 32;

    logic          clk1 = 1'b0;
    logic          clk2 = 1'b0;
    logic          rst1_n = 1'b0;
    logic          rst2_n = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_busy;
    logic          src_overrun;
    logic [DW-1:0] dst_data;
    logic          dst_valid;
    logic          dst_ready_w;

    logic dir_rdy = 1'b1;
    logic rnd_rdy = 1'b1;
    logic rnd_mode = 1'b0;
    logic sb_en = 1'b0;

    real h1 = 10.0;
    real h2 = 40.690 / 2.0;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ovr = 0;
    int got_ovr = 0;

    logic [DW-1:0] got[$];
    logic [DW-1:0] acc[$];

    assign dst_ready_w = rnd_mode ? rnd_rdy : dir_rdy;

    i2s_data_sync #(.DW(DW)) dut (
        .clk1        (clk1),
        .rst1_n      (rst1_n),
        .clk2        (clk2),
        .rst2_n      (rst2_n),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_busy    (src_busy),
        .src_overrun (src_overrun),
        .dst_data    (dst_data),
        .dst_valid   (dst_valid),
        .dst_ready   (dst_ready_w)
    );

    always #(h1) clk1 = ~clk1;
    always #(h2) clk2 = ~clk2;

    always @(negedge clk1) rnd_rdy = ($urandom_range(0, 3) != 0);

    always @(posedge clk1)
        if (rst1_n && dst_valid && dst_ready_w) got.push_back(dst_data);

    always @(posedge clk2)
        if (sb_en && rst2_n) begin
            if (src_valid && !src_busy) acc.push_back(src_data);
            if (src_valid && src_busy) exp_ovr++;
            if (src_overrun) got_ovr++;
        end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        @(negedge clk2);
        src_data = d;
        src_valid = 1'b1;
        @(posedge clk2);
        #1 src_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!dst_valid && n < 300) begin
            @(negedge clk1);
            n++;
        end
        if (!dst_valid) check(tag, 64'd0, 64'd1);
    endtask

    task automatic wait_free(input string tag);
        int n;
        n = 0;
        while (src_busy && n < 600) begin
            @(negedge clk2);
            n++;
        end
        if (src_busy) check(tag, 64'd1, 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((src_busy || dst_valid) && n < 2000) begin
            @(negedge clk1);
            n++;
        end
        if (src_busy || dst_valid) check(tag, 64'd1, 64'd0);
        repeat (6) @(negedge clk1);
    endtask

    task automatic run_stream(input string tag, input real a, input real b,
                              input int words);
        int c;
        h1 = a;
        h2 = b;
        repeat (4) @(negedge clk2);
        got.delete();
        acc.delete();
        exp_ovr = 0;
        got_ovr = 0;
        sb_en = 1'b1;
        rnd_mode = 1'b1;
        c = 0;
        while (acc.size() < words && c < 40000) begin
            @(negedge clk2);
            src_valid = ($urandom_range(0, 2) != 0);
            src_data = $urandom;
            c++;
        end
        @(negedge clk2);
        src_valid = 1'b0;
        check({tag, "_acc_reached"}, 64'(acc.size() >= words), 64'd1);
        rnd_mode = 1'b0;
        dir_rdy = 1'b1;
        wait_idle({tag, "_drain"});
        repeat (3) @(negedge clk2);
        sb_en = 1'b0;
        check({tag, "_count"}, 64'(got.size()), 64'(acc.size()));
        for (int i = 0; i < acc.size() && i < got.size(); i++)
            check({tag, "_word"}, 64'(got[i]), 64'(acc[i]));
        check({tag, "_ovr"}, 64'(got_ovr), 64'(exp_ovr));
    endtask

    initial begin
        int n;

        // reset values
        #25;
        check("rst_busy", 64'(src_busy), 64'd0);
        check("rst_ovr", 64'(src_overrun), 64'd0);
        check("rst_valid", 64'(dst_valid), 64'd0);
        check("rst_data", 64'(dst_data), 64'd0);
        @(negedge clk1) rst1_n = 1'b1;
        @(negedge clk2) rst2_n = 1'b1;
        repeat (4) @(negedge clk1);

        // single word, latency from req rise to dst_valid
        got.delete();
        @(negedge clk2);
        src_data = 32'hA5A5_1234;
        src_valid = 1'b1;
        @(posedge clk2);
        #1 src_valid = 1'b0;
        n = 0;
        while (!dst_valid && n < 20) begin
            @(posedge clk1);
            n++;
            #1;
        end
        check("lat_edges", 64'(n), 64'd3);
        check("single_data", 64'(dst_data), 64'hA5A5_1234);
        check("single_busy", 64'(src_busy), 64'd1);
        wait_idle("single_idle");
        check("single_busy_low", 64'(src_busy), 64'd0);
        check("single_count", 64'(got.size()), 64'd1);

        // overrun: second strobe two clk2 cycles after the first
        got.delete();
        strobe(32'h1);
        check("ovr_quiet", 64'(src_overrun), 64'd0);
        @(posedge clk2);
        strobe(32'h2);
        check("ovr_pulse", 64'(src_overrun), 64'd1);
        @(posedge clk2);
        #1;
        check("ovr_clear", 64'(src_overrun), 64'd0);
        wait_idle("ovr_idle");
        check("ovr_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) check("ovr_word", 64'(got[0]), 64'h1);

        // backpressure
        got.delete();
        dir_rdy = 1'b0;
        strobe(32'h11);
        wait_valid("bp_valid1");
        check("bp_data1", 64'(dst_data), 64'h11);
        wait_free("bp_free");
        strobe(32'h22);
        repeat (20) @(negedge clk1);
        check("bp_busy", 64'(src_busy), 64'd1);
        check("bp_hold", 64'(dst_data), 64'h11);
        check("bp_hold_v", 64'(dst_valid), 64'd1);
        dir_rdy = 1'b1;
        @(negedge clk1);
        dir_rdy = 1'b0;
        check("bp_data2", 64'(dst_data), 64'h22);
        check("bp_valid2", 64'(dst_valid), 64'd1);
        check("bp_got1", 64'(got.size()), 64'd1);
        dir_rdy = 1'b1;
        wait_idle("bp_idle");
        check("bp_got2", 64'(got.size()), 64'd2);
        if (got.size() > 1) check("bp_word2", 64'(got[1]), 64'h22);

        // rst2_n while ack=1
        got.delete();
        strobe(32'h33);
        wait_valid("r2_valid");
        rst2_n = 1'b0;
        #1;
        check("r2_busy", 64'(src_busy), 64'd0);
        @(posedge clk1);
        #1;
        check("r2_word", 64'(got.size()), 64'd1);
        got.delete();
        repeat (4) @(negedge clk2);
        rst2_n = 1'b1;
        repeat (40) @(negedge clk1);
        check("r2_no_spur", 64'(got.size()), 64'd0);
        check("r2_valid_low", 64'(dst_valid), 64'd0);
        check("r2_busy_end", 64'(src_busy), 64'd0);

        // rst1_n while req=1
        got.delete();
        strobe(32'h44);
        rst1_n = 1'b0;
        repeat (5) @(negedge clk1);
        check("r1_valid_rst", 64'(dst_valid), 64'd0);
        check("r1_busy_rst", 64'(src_busy), 64'd1);
        rst1_n = 1'b1;
        wait_idle("r1_idle");
        check("r1_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) check("r1_word", 64'(got[0]), 64'h44);

        // random streams over clock ratios clk1:clk2 = 4:1, 1:1, 1:3
        run_stream("s41", 5.0, 20.0, 334);
        run_stream("s11", 10.0, 10.7, 333);
        run_stream("s13", 15.0, 5.0, 333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
